// File: rtl/cm_nest_cnt.sv
// cm_nest_cnt: three-level (x fastest, then y, then c) index walker
// for the feature-map fetch path, one tuple per valid/ready beat.
module cm_nest_cnt #(
   parameter int C_WIDTH = 8
) (
   input  logic               I_clk,
   input  logic               I_rst_n,
   input  logic               I_start,
   input  logic               I_clr,
   input  logic [C_WIDTH-1:0] I_x_upper,
   input  logic [C_WIDTH-1:0] I_y_upper,
   input  logic [C_WIDTH-1:0] I_c_upper,
   input  logic               I_ready,
   output logic               O_valid,
   output logic [C_WIDTH-1:0] O_x,
   output logic [C_WIDTH-1:0] O_y,
   output logic [C_WIDTH-1:0] O_c,
   output logic               O_last,
   output logic               O_busy,
   output logic               O_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [C_WIDTH-1:0] x, y, c;
   logic [C_WIDTH-1:0] x_nxt, y_nxt, c_nxt;
   logic [C_WIDTH-1:0] xu, yu, cu;
   logic               latch;
   logic               hs;
   logic               x_end, y_end, last;

   assign x_end = (x == xu);
   assign y_end = (y == yu);
   assign last  = (state == RUN) && x_end && y_end && (c == cu);
   assign hs    = (state == RUN) && I_ready;

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state <= IDLE;
         x     <= '0;
         y     <= '0;
         c     <= '0;
         xu    <= '0;
         yu    <= '0;
         cu    <= '0;
      end else begin
         state <= state_nxt;
         x     <= x_nxt;
         y     <= y_nxt;
         c     <= c_nxt;
         if (latch) begin
            xu <= I_x_upper;
            yu <= I_y_upper;
            cu <= I_c_upper;
         end
      end
   end

   // Compare-before-increment keeps all-ones bounds overflow-free.
   always_comb begin
      state_nxt = state;
      x_nxt     = x;
      y_nxt     = y;
      c_nxt     = c;
      latch     = 1'b0;
      if (I_clr) begin
         state_nxt = IDLE;
         x_nxt     = '0;
         y_nxt     = '0;
         c_nxt     = '0;
      end else begin
         unique case (state)
            IDLE: begin
               x_nxt = '0;
               y_nxt = '0;
               c_nxt = '0;
               if (I_start) begin
                  latch     = 1'b1;
                  state_nxt = RUN;
               end
            end
            RUN: begin
               if (hs) begin
                  if (last) begin
                     state_nxt = DONE;
                     x_nxt     = '0;
                     y_nxt     = '0;
                     c_nxt     = '0;
                  end else if (!x_end) begin
                     x_nxt = x + 1'b1;
                  end else begin
                     x_nxt = '0;
                     if (!y_end) begin
                        y_nxt = y + 1'b1;
                     end else begin
                        y_nxt = '0;
                        c_nxt = c + 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               state_nxt = IDLE;
            end
            default: begin
               state_nxt = IDLE;
               x_nxt     = '0;
               y_nxt     = '0;
               c_nxt     = '0;
            end
         endcase
      end
   end

   assign O_valid = (state == RUN);
   assign O_busy  = (state == RUN) || (state == DONE);
   assign O_done  = (state == DONE);
   assign O_x     = x;
   assign O_y     = y;
   assign O_c     = c;
   assign O_last  = last;

endmodule

// File: tb/tb_cm_nest_cnt.sv
// Bench for cm_nest_cnt: directed vector table plus hand-written
// sequences for full runs, bound changes and asynchronous reset.
module tb_cm_nest_cnt;

   logic       clk;
   logic       rst_n;
   logic       start, clr, ready;
   logic [7:0] xu, yu, cu;
   logic       valid, last, busy, done;
   logic [7:0] ox, oy, oc;

   int total = 0;
   int bad   = 0;

   cm_nest_cnt #(.C_WIDTH(8)) dut (
      .I_clk     (clk),
      .I_rst_n   (rst_n),
      .I_start   (start),
      .I_clr     (clr),
      .I_x_upper (xu),
      .I_y_upper (yu),
      .I_c_upper (cu),
      .I_ready   (ready),
      .O_valid   (valid),
      .O_x       (ox),
      .O_y       (oy),
      .O_c       (oc),
      .O_last    (last),
      .O_busy    (busy),
      .O_done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       st, cl, rd;
      logic [7:0] xu, yu, cu;
      logic       v;
      logic [7:0] x, y, c;
      logic       l, b, d;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      input logic st, cl, rd,
      input logic [7:0] bx, by, bc,
      input logic v,
      input logic [7:0] ex, ey, ec,
      input logic l, b, d);
      vec_t r;
      r.st = st; r.cl = cl; r.rd = rd;
      r.xu = bx; r.yu = by; r.cu = bc;
      r.v = v; r.x = ex; r.y = ey; r.c = ec;
      r.l = l; r.b = b; r.d = d;
      return r;
   endfunction

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [30:0] outs();
      return {valid, ox, oy, oc, last, busy, done};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      int beats;
      logic [30:0] expv;

      rst_n = 1'b0; start = 0; clr = 0; ready = 0;
      xu = 0; yu = 0; cu = 0;
      #22;
      chk("reset_outs", {1'b0, outs()}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_after_rst", {1'b0, outs()}, 32'd0);

      // all bounds 0, start ignored in DONE, restart at earliest slot
      tbl.push_back(mk(1,0,0, 0,0,0, 1, 0,0,0, 1,1,0));
      tbl.push_back(mk(0,0,1, 0,0,0, 0, 0,0,0, 0,1,1));
      tbl.push_back(mk(1,0,0, 0,0,0, 0, 0,0,0, 0,0,0));
      tbl.push_back(mk(1,0,0, 0,0,0, 1, 0,0,0, 1,1,0));
      tbl.push_back(mk(0,0,1, 0,0,0, 0, 0,0,0, 0,1,1));
      tbl.push_back(mk(0,0,0, 0,0,0, 0, 0,0,0, 0,0,0));
      // x=3 with ready toggling; start during RUN ignored
      tbl.push_back(mk(1,0,1, 3,0,0, 1, 0,0,0, 0,1,0));
      tbl.push_back(mk(0,0,1, 3,0,0, 1, 1,0,0, 0,1,0));
      tbl.push_back(mk(1,0,0, 3,0,0, 1, 1,0,0, 0,1,0));
      tbl.push_back(mk(0,0,0, 3,0,0, 1, 1,0,0, 0,1,0));
      tbl.push_back(mk(0,0,1, 3,0,0, 1, 2,0,0, 0,1,0));
      tbl.push_back(mk(0,0,1, 3,0,0, 1, 3,0,0, 1,1,0));
      tbl.push_back(mk(0,0,0, 3,0,0, 1, 3,0,0, 1,1,0));
      tbl.push_back(mk(0,0,0, 3,0,0, 1, 3,0,0, 1,1,0));
      tbl.push_back(mk(0,0,1, 3,0,0, 0, 0,0,0, 0,1,1));
      tbl.push_back(mk(0,0,0, 3,0,0, 0, 0,0,0, 0,0,0));
      // clr on third beat beats start and handshake
      tbl.push_back(mk(1,0,0, 3,3,0, 1, 0,0,0, 0,1,0));
      tbl.push_back(mk(0,0,1, 3,3,0, 1, 1,0,0, 0,1,0));
      tbl.push_back(mk(0,0,1, 3,3,0, 1, 2,0,0, 0,1,0));
      tbl.push_back(mk(1,1,1, 3,3,0, 0, 0,0,0, 0,0,0));
      tbl.push_back(mk(0,0,0, 3,3,0, 0, 0,0,0, 0,0,0));
      tbl.push_back(mk(1,0,0, 1,0,0, 1, 0,0,0, 0,1,0));
      tbl.push_back(mk(0,0,1, 1,0,0, 1, 1,0,0, 1,1,0));
      tbl.push_back(mk(0,0,1, 1,0,0, 0, 0,0,0, 0,1,1));
      tbl.push_back(mk(0,0,0, 1,0,0, 0, 0,0,0, 0,0,0));

      foreach (tbl[i]) begin
         start = tbl[i].st; clr = tbl[i].cl; ready = tbl[i].rd;
         xu = tbl[i].xu; yu = tbl[i].yu; cu = tbl[i].cu;
         tick();
         expv = {tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].c,
                 tbl[i].l, tbl[i].b, tbl[i].d};
         chk($sformatf("vec%0d", i), {1'b0, outs()}, {1'b0, expv});
      end

      // 12-beat run x=2 y=1 c=1 with ready held high
      start = 1; clr = 0; ready = 1; xu = 2; yu = 1; cu = 1;
      tick();
      start = 0;
      for (int c = 0; c <= 1; c++)
         for (int y = 0; y <= 1; y++)
            for (int x = 0; x <= 2; x++) begin
               expv = {1'b1, 8'(x), 8'(y), 8'(c),
                       (x == 2 && y == 1 && c == 1), 1'b1, 1'b0};
               chk($sformatf("run12_%0d%0d%0d", x, y, c),
                   {1'b0, outs()}, {1'b0, expv});
               tick();
            end
      chk("run12_done", {1'b0, outs()}, {1'b0, 1'b0, 24'd0, 3'b011});
      tick();
      chk("run12_idle", {1'b0, outs()}, 32'd0);

      // bounds changed after start have no effect
      start = 1; xu = 1; yu = 1; cu = 0; ready = 1;
      tick();
      start = 0; xu = 7; yu = 5;
      beats = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (valid) begin
            chk($sformatf("latch_x%0d", beats), ox, beats % 2);
            chk($sformatf("latch_y%0d", beats), oy, beats / 2);
            beats++;
         end
         tick();
      end
      chk("latch_beats", beats, 4);
      chk("latch_done", done, 1);
      tick();

      // asynchronous reset mid-run
      start = 1; xu = 5; yu = 5; cu = 5; ready = 1;
      tick();
      start = 0;
      tick();
      tick();
      chk("pre_rst_x", ox, 2);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst", {1'b0, outs()}, 32'd0);
      start = 1; ready = 1;
      tick();
      tick();
      chk("rst_hold", {1'b0, outs()}, 32'd0);
      #2;
      rst_n = 1'b1;
      start = 0;
      tick();
      chk("post_rst_idle", {1'b0, outs()}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
